sbinit: RTL and testbench
=========================

Name: sbinit

Overview:
- Link-training sideband-initialization stage that runs immediately upstream of MBINIT.
- When enabled by the LTSM, it exchanges out-of-reset and SBINIT done request/response sideband messages with the link partner.
- It raises SBINIT_done_o on success; the LTSM uses that to enable MBINIT.
- It shares the sideband TX/RX message handshake and the state-timeout reset output with MBINIT.

Parameters:
- RESEND_CYCLES, 100000: cycles between out-of-reset retransmissions while the partner's out-of-reset is still pending (1 ms at 100 MHz).
- TIMEOUT_CYCLES, 800000: maximum cycles spent in SBINIT before error (8 ms at 100 MHz).

Ports:
- clk_100MHz  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- enable_i  input  1  LTSM grants the SBINIT state; level.
- SBINIT_done_o  output  1  sequence complete; held while enable_i stays high.
- SBINIT_timeout_o  output  1  timeout error; held while enable_i stays high.
- TX_msg_o  output  SB_msg_t  message to transmit; codes SBINIT_OUT_OF_RESET, SBINIT_DONE_REQ, SBINIT_DONE_RESP.
- TX_msg_valid_o  output  1  TX_msg_o valid; held until acknowledged.
- TX_msg_valid_ack_i  input  1  sideband TX accepted the message this cycle.
- RX_msg_i  input  SB_msg_t  received message.
- RX_msg_valid_i  input  1  RX_msg_i valid.
- RX_msg_req_o  output  1  block consumes RX_msg_i; consume happens when RX_msg_req_o && RX_msg_valid_i.
- reset_state_timeout_counter_o  output  1  one-cycle pulse on every state entry.

Behaviour:
- Reset and IDLE values:
  - All outputs 0 under reset; TX_msg_o is the all-zero SB_msg_t.
  - State goes to IDLE; flags and counters clear.
- States: IDLE, OOR_TX, OOR_WAIT, REQ_TX, XCHG, RESP_TX, DONE, ERROR.
- IDLE:
  - enable_i=1 moves to OOR_TX on the next cycle.
  - The timeout counter starts at 0.
- TX rule (OOR_TX, REQ_TX, RESP_TX):
  - TX_msg_valid_o=1 and TX_msg_o are registered on state entry and stay stable until the cycle TX_msg_valid_ack_i=1.
  - TX_msg_valid_o drops the cycle after the ack.
  - A simultaneous valid and ack completes in one cycle.
- OOR_TX: sends SBINIT_OUT_OF_RESET; on ack goes to OOR_WAIT.
- OOR_WAIT:
  - Resend counter counts up.
  - Reaching RESEND_CYCLES-1 returns to OOR_TX.
  - Receiving the partner's SBINIT_OUT_OF_RESET goes to REQ_TX.
- REQ_TX: sends SBINIT_DONE_REQ; on ack goes to XCHG.
- XCHG:
  - got_req set with got_resp clear: go to RESP_TX.
  - got_req set with got_resp set: go to RESP_TX, then DONE after the ack.
  - sent_resp set with got_resp set: go to DONE.
- RESP_TX: sends SBINIT_DONE_RESP; on ack sets sent_resp and returns to XCHG.
  - Exception: go directly to DONE if got_resp is already set.
- RX handling:
  - RX_msg_req_o=1 in all states except IDLE, DONE and ERROR.
  - got_req and got_resp latch at any time after the partner's out-of-reset has been seen, including during TX states.
  - Partner DONE_REQ arriving before our REQ_TX is acked is remembered.
  - Duplicate out-of-reset after OOR_WAIT is consumed and ignored.
  - Any other code is consumed and discarded.
- DONE: SBINIT_done_o=1, TX_msg_valid_o=0, RX_msg_req_o=0.
- Timeout:
  - The counter increments every cycle while in OOR_TX, OOR_WAIT, REQ_TX, XCHG or RESP_TX.
  - Reaching TIMEOUT_CYCLES-1 forces ERROR on the next cycle and overrides any pending transition.
  - ERROR: SBINIT_timeout_o=1, TX_msg_valid_o=0 even mid-handshake, RX_msg_req_o=0.
- reset_state_timeout_counter_o pulses for exactly 1 cycle on each entry into a new state.
  - Repeated OOR_WAIT to OOR_TX cycles each pulse.
- enable_i deasserts in any state:
  - Next cycle goes to IDLE with all outputs 0 and flags and counters cleared.
  - Any in-flight TX is abandoned.
  - A re-enable restarts from OOR_TX.
- Simultaneous ack and RX receipt in the same cycle: both take effect.

Test Plan:
- Clean exchange: enable_i=1; ack every TX after 2 cycles; partner sends OOR, then DONE_REQ, then DONE_RESP. Required: TX sequence OOR, DONE_REQ, DONE_RESP; SBINIT_done_o=1; no timeout; one reset_state_timeout_counter_o pulse per state entry.
- Early partner request: partner DONE_REQ arrives while our DONE_REQ is unacked for 10 cycles. Required: request is remembered; DONE_RESP is sent after the ack; DONE follows DONE_RESP.
- Resend: partner silent for 2.5*RESEND_CYCLES, then sends OOR. Required: exactly 3 OOR transmissions, then DONE_REQ.
- Timeout: partner never responds. Required: after TIMEOUT_CYCLES, SBINIT_timeout_o=1, TX_msg_valid_o=0, SBINIT_done_o stays 0.
- Abort mid-handshake: enable_i drops in REQ_TX with valid high and no ack. Required: next cycle all outputs 0. On re-enable, the first TX is OOR.
- Junk RX: unrelated codes and duplicate OOR injected in XCHG. Required: all consumed via RX_msg_req_o; state unaffected.

Source files
------------

// File: rtl/sbinit.sv
// SBINIT link-training stage: out-of-reset then DONE req/resp exchange with the partner over the sideband.
// Registered outputs are one cycle after the state decision. TX holds until ack; RX is accepted whenever the stage is active.
package sbinit_pkg;
  typedef logic [7:0] SB_msg_t;
  localparam SB_msg_t SBINIT_OUT_OF_RESET = 8'h91;
  localparam SB_msg_t SBINIT_DONE_REQ     = 8'h95;
  localparam SB_msg_t SBINIT_DONE_RESP    = 8'h9A;
endpackage

module sbinit
  import sbinit_pkg::*;
#(
  parameter int RESEND_CYCLES  = 100000,
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  logic    clk_100MHz,
  input  logic    reset,
  input  logic    enable_i,
  output logic    SBINIT_done_o,
  output logic    SBINIT_timeout_o,
  output SB_msg_t TX_msg_o,
  output logic    TX_msg_valid_o,
  input  logic    TX_msg_valid_ack_i,
  input  SB_msg_t RX_msg_i,
  input  logic    RX_msg_valid_i,
  output logic    RX_msg_req_o,
  output logic    reset_state_timeout_counter_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] OOR_TX   = 3'd1;
  localparam logic [2:0] OOR_WAIT = 3'd2;
  localparam logic [2:0] REQ_TX   = 3'd3;
  localparam logic [2:0] XCHG     = 3'd4;
  localparam logic [2:0] RESP_TX  = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;
  localparam logic [2:0] ERROR    = 3'd7;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RESEND_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RS_LAST = RW'(RESEND_CYCLES - 1);

  logic [2:0]    state, next_state;
  logic [TW-1:0] to_cnt;
  logic [RW-1:0] rs_cnt;
  logic          got_oor, got_req, got_resp, sent_resp;
  logic          tx_vld, state_pulse;
  SB_msg_t       tx_msg, tx_msg_next;
  logic          active, rx_fire, ack, rx_oor, rx_req, rx_resp, tx_next;

  assign active  = (state == OOR_TX) || (state == OOR_WAIT) || (state == REQ_TX) ||
                   (state == XCHG) || (state == RESP_TX);
  assign rx_fire = active && RX_msg_valid_i;
  assign ack     = tx_vld && TX_msg_valid_ack_i;
  assign rx_oor  = rx_fire && (RX_msg_i == SBINIT_OUT_OF_RESET);
  // Req/resp only count once the partner has announced it is out of reset.
  assign rx_req  = rx_fire && got_oor && (RX_msg_i == SBINIT_DONE_REQ);
  assign rx_resp = rx_fire && got_oor && (RX_msg_i == SBINIT_DONE_RESP);

  always_comb begin
    next_state = state;
    if (!enable_i) begin
      next_state = IDLE;
    end else if (active && (to_cnt == TO_LAST)) begin
      next_state = ERROR;
    end else begin
      case (state)
        IDLE:     next_state = OOR_TX;
        OOR_TX:   if (ack) next_state = OOR_WAIT;
        OOR_WAIT: begin
          if (got_oor || rx_oor)      next_state = REQ_TX;
          else if (rs_cnt == RS_LAST) next_state = OOR_TX;
        end
        REQ_TX:   if (ack) next_state = XCHG;
        XCHG: begin
          if (got_req && !sent_resp)      next_state = RESP_TX;
          else if (sent_resp && got_resp) next_state = DONE;
        end
        RESP_TX:  if (ack) next_state = (got_resp || rx_resp) ? DONE : XCHG;
        default:  next_state = state;
      endcase
    end
  end

  always_comb begin
    tx_next     = 1'b1;
    tx_msg_next = '0;
    case (next_state)
      OOR_TX:  tx_msg_next = SBINIT_OUT_OF_RESET;
      REQ_TX:  tx_msg_next = SBINIT_DONE_REQ;
      RESP_TX: tx_msg_next = SBINIT_DONE_RESP;
      default: tx_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state       <= IDLE;
      to_cnt      <= '0;
      rs_cnt      <= '0;
      got_oor     <= 1'b0;
      got_req     <= 1'b0;
      got_resp    <= 1'b0;
      sent_resp   <= 1'b0;
      tx_vld      <= 1'b0;
      tx_msg      <= '0;
      state_pulse <= 1'b0;
    end else begin
      state       <= next_state;
      state_pulse <= (next_state != state) && (next_state != IDLE);
      // No TX state ever re-enters itself after an ack, so valid follows the next state.
      tx_vld      <= tx_next;
      tx_msg      <= tx_msg_next;
      if (next_state == IDLE) begin
        to_cnt    <= '0;
        rs_cnt    <= '0;
        got_oor   <= 1'b0;
        got_req   <= 1'b0;
        got_resp  <= 1'b0;
        sent_resp <= 1'b0;
      end else begin
        if (active) to_cnt <= to_cnt + 1'b1;
        rs_cnt <= ((state == OOR_WAIT) && (next_state == OOR_WAIT)) ? rs_cnt + 1'b1 : '0;
        if (rx_oor)  got_oor  <= 1'b1;
        if (rx_req)  got_req  <= 1'b1;
        if (rx_resp) got_resp <= 1'b1;
        if ((state == RESP_TX) && ack) sent_resp <= 1'b1;
      end
    end
  end

  assign SBINIT_done_o                 = (state == DONE);
  assign SBINIT_timeout_o              = (state == ERROR);
  assign TX_msg_o                      = tx_msg;
  assign TX_msg_valid_o                = tx_vld;
  assign RX_msg_req_o                  = active;
  assign reset_state_timeout_counter_o = state_pulse;

endmodule

// File: tb/tb_sbinit.sv
// Directed bench for sbinit: cycle vector table plus resend, early-request/junk and timeout sequences.
module tb_sbinit;
  import sbinit_pkg::*;

  localparam int RS = 16;
  localparam int TO = 400;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam SB_msg_t NONE   = 8'h00;
  localparam SB_msg_t OOR    = SBINIT_OUT_OF_RESET;
  localparam SB_msg_t REQ    = SBINIT_DONE_REQ;
  localparam SB_msg_t RESP   = SBINIT_DONE_RESP;
  localparam SB_msg_t JUNK_A = 8'h33;
  localparam SB_msg_t JUNK_B = 8'hFF;

  logic    clk = 1'b0;
  logic    reset, enable, ack, rx_vld;
  SB_msg_t rx_msg, tx_msg;
  logic    done, tmo, tx_vld, rx_req, pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sbinit #(.RESEND_CYCLES(RS), .TIMEOUT_CYCLES(TO)) dut (
    .clk_100MHz(clk),
    .reset(reset),
    .enable_i(enable),
    .SBINIT_done_o(done),
    .SBINIT_timeout_o(tmo),
    .TX_msg_o(tx_msg),
    .TX_msg_valid_o(tx_vld),
    .TX_msg_valid_ack_i(ack),
    .RX_msg_i(rx_msg),
    .RX_msg_valid_i(rx_vld),
    .RX_msg_req_o(rx_req),
    .reset_state_timeout_counter_o(pulse)
  );

  typedef struct {
    logic    en, ak, rv;
    SB_msg_t rm;
    logic    e_vld;
    SB_msg_t e_msg;
    logic    e_rxreq, e_done, e_tmo, e_pulse;
  } vec_t;

  function automatic vec_t mk(logic en, logic ak, logic rv, SB_msg_t rm, logic ev, SB_msg_t em,
                              logic er, logic ed, logic et, logic ep);
    vec_t v;
    v.en = en; v.ak = ak; v.rv = rv; v.rm = rm;
    v.e_vld = ev; v.e_msg = em; v.e_rxreq = er; v.e_done = ed; v.e_tmo = et; v.e_pulse = ep;
    return v;
  endfunction

  function automatic logic [12:0] outs();
    return {tx_vld, tx_msg, rx_req, done, tmo, pulse};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  vec_t vecs[18];
  int oor_cnt, pulse_cnt, cyc;
  logic prev_vld;
  logic found;

  initial begin
    // Clean exchange, then abort in REQ_TX with an unacked request, then re-enable.
    vecs[0]  = mk(H,L,L,NONE, H,OOR, H,L,L,H);
    vecs[1]  = mk(H,L,L,NONE, H,OOR, H,L,L,L);
    vecs[2]  = mk(H,H,L,NONE, L,NONE,H,L,L,H);
    vecs[3]  = mk(H,L,H,OOR,  H,REQ, H,L,L,H);
    vecs[4]  = mk(H,L,H,REQ,  H,REQ, H,L,L,L);
    vecs[5]  = mk(H,H,L,NONE, L,NONE,H,L,L,H);
    vecs[6]  = mk(H,L,L,NONE, H,RESP,H,L,L,H);
    vecs[7]  = mk(H,L,H,RESP, H,RESP,H,L,L,L);
    vecs[8]  = mk(H,H,L,NONE, L,NONE,L,H,L,H);
    vecs[9]  = mk(H,L,L,NONE, L,NONE,L,H,L,L);
    vecs[10] = mk(L,L,L,NONE, L,NONE,L,L,L,L);
    vecs[11] = mk(H,L,L,NONE, H,OOR, H,L,L,H);
    vecs[12] = mk(H,H,H,OOR,  L,NONE,H,L,L,H);
    vecs[13] = mk(H,L,L,NONE, H,REQ, H,L,L,H);
    vecs[14] = mk(H,L,L,NONE, H,REQ, H,L,L,L);
    vecs[15] = mk(L,L,L,NONE, L,NONE,L,L,L,L);
    vecs[16] = mk(H,L,L,NONE, H,OOR, H,L,L,H);
    vecs[17] = mk(L,L,L,NONE, L,NONE,L,L,L,L);

    reset = 1'b1; enable = 1'b0; ack = 1'b0; rx_vld = 1'b0; rx_msg = NONE;
    repeat (3) tick();
    chk("reset_outputs", 32'(outs()), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      enable = vecs[i].en; ack = vecs[i].ak; rx_vld = vecs[i].rv; rx_msg = vecs[i].rm;
      tick();
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({vecs[i].e_vld, vecs[i].e_msg, vecs[i].e_rxreq, vecs[i].e_done,
               vecs[i].e_tmo, vecs[i].e_pulse}));
    end
    ack = 1'b0; rx_vld = 1'b0; rx_msg = NONE;

    // Early partner request while our DONE_REQ waits 10 cycles for its ack, then junk in XCHG.
    enable = 1'b1; tick();
    ack = 1'b1; tick();
    ack = 1'b0; rx_vld = 1'b1; rx_msg = OOR; tick();
    for (int i = 0; i < 10; i++) begin
      rx_vld = (i == 4); rx_msg = REQ;
      tick();
      chk($sformatf("req_hold%0d", i), 32'({tx_vld, tx_msg}), 32'({H, REQ}));
    end
    rx_vld = 1'b0; ack = 1'b1; tick();
    chk("early_xchg", 32'({tx_vld, pulse}), 32'({L, H}));
    ack = 1'b0; tick();
    chk("early_resp_tx", 32'({tx_vld, tx_msg}), 32'({H, RESP}));
    ack = 1'b1; tick();
    ack = 1'b0;
    chk("resp_acked_xchg", 32'({tx_vld, done, pulse}), 32'({L, L, H}));
    for (int j = 0; j < 3; j++) begin
      rx_vld = 1'b1; rx_msg = (j == 0) ? JUNK_A : ((j == 1) ? OOR : JUNK_B);
      chk($sformatf("junk_req%0d", j), 32'(rx_req), 32'd1);
      tick();
      chk($sformatf("junk_state%0d", j), 32'({tx_vld, rx_req, done, tmo, pulse}),
          32'({L, H, L, L, L}));
    end
    rx_msg = RESP; tick();
    rx_vld = 1'b0;
    chk("resp_latched", 32'(done), 32'd0);
    tick();
    chk("done_after_resp", 32'({done, pulse, tx_vld}), 32'({H, H, L}));
    tick();
    chk("done_held", 32'({done, pulse, rx_req}), 32'({H, L, L}));
    enable = 1'b0; tick();

    // Partner silent for 2.5 resend periods: three OOR sends, then DONE_REQ.
    enable = 1'b1; oor_cnt = 0; pulse_cnt = 0; found = 1'b0; cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      cyc = c;
      if (pulse) pulse_cnt++;
      if (tx_vld && tx_msg == REQ) begin
        found = 1'b1;
        break;
      end
      ack = tx_vld;
      if (tx_vld && tx_msg == OOR) oor_cnt++;
      rx_vld = (c == 40); rx_msg = OOR;
    end
    ack = 1'b0; rx_vld = 1'b0;
    chk("resend_req_seen", 32'(found), 32'd1);
    chk("resend_oor_count", 32'(oor_cnt), 32'd3);
    chk("resend_pulses", 32'(pulse_cnt), 32'd7);
    chk("resend_req_cycle", 32'(cyc), 32'd41);
    enable = 1'b0; tick();

    // Nothing ever acks or answers: ERROR after TO cycles, dropping a valid mid-handshake.
    enable = 1'b1; found = 1'b0; cyc = 0; prev_vld = 1'b0;
    for (int c = 1; c <= TO + 20; c++) begin
      prev_vld = tx_vld;
      tick();
      cyc = c;
      if (tmo) begin
        found = 1'b1;
        break;
      end
    end
    chk("timeout_seen", 32'(found), 32'd1);
    chk("timeout_cycle", 32'(cyc), 32'(TO + 1));
    chk("timeout_prev_vld", 32'(prev_vld), 32'd1);
    chk("timeout_outputs", 32'({tx_vld, rx_req, done, pulse}), 32'({L, L, L, H}));
    repeat (5) tick();
    chk("timeout_held", 32'({tmo, done, tx_vld}), 32'({H, L, L}));
    enable = 1'b0; tick();
    chk("idle_after_error", 32'(outs()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
